// File: rtl/lcd_serial_rx.sv
// lcd_serial_rx: receive side of the 4-wire serial LCD bus (sel, cmd/data,
// sclk, sdata). The bus is oversampled in the in_clk domain and bytes are
// assembled MSB first. CASET, RASET, RAMWR and SWRESET are decoded, and RGB565
// pixels are emitted together with their controller x/y coordinates.
// Optional build macro: LCD_SERIAL_RX_ERRCNT_EN adds out_err_count, a
// saturating count of aborted bytes and of dropped half pixels.
//
// state | meaning
// IDLE  | waiting for a command; data bytes are ignored
// CASET | collecting 4 column-window parameter bytes
// RASET | collecting 4 row-window parameter bytes
// RAMWR | streaming pixel data (two bytes per pixel), out_busy high
module lcd_serial_rx #(
  parameter int SERIAL_BITS = 8,
  parameter int PIXEL_BITS  = 16,
  parameter int ADDR_BITS   = 9,
  parameter int DEF_XEND    = 239,
  parameter int DEF_YEND    = 319
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_ser_sel,
  input  logic                   in_ser_cmd,
  input  logic                   in_ser_clk,
  input  logic                   in_ser_data,
  output logic [SERIAL_BITS-1:0] out_cmd,
  output logic                   out_cmd_valid,
  output logic [PIXEL_BITS-1:0]  out_pixel,
  output logic [ADDR_BITS-1:0]   out_x,
  output logic [ADDR_BITS-1:0]   out_y,
  output logic                   out_pixel_valid,
`ifdef LCD_SERIAL_RX_ERRCNT_EN
  output logic [7:0]             out_err_count,
`endif
  output logic                   out_busy
);

  localparam int CNT_W = $clog2(SERIAL_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SERIAL_BITS - 1);
  localparam logic [ADDR_BITS-1:0] XEND_RST = ADDR_BITS'(DEF_XEND);
  localparam logic [ADDR_BITS-1:0] YEND_RST = ADDR_BITS'(DEF_YEND);
  localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CASET = 2'd1,
    RASET = 2'd2,
    RAMWR = 2'd3
  } state_t;

  // bus synchronisers; clk_s3_q is the previous synced clock for edge detect
  logic sel_s1_q, sel_s2_q, cmd_s1_q, cmd_s2_q;
  logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;

  logic [SERIAL_BITS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ser_rise, byte_done;
  logic [SERIAL_BITS-1:0] byte_val;

  state_t                 state_q, state_d;
  logic [1:0]             pidx_q, pidx_d;
  logic [SERIAL_BITS-1:0] p_shi_q, p_shi_d, p_slo_q, p_slo_d, p_ehi_q, p_ehi_d;
  logic [ADDR_BITS-1:0]   xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [ADDR_BITS-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic                   phase_q, phase_d;
  logic [SERIAL_BITS-1:0] pix_hi_q, pix_hi_d;
  logic [SERIAL_BITS-1:0] cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [PIXEL_BITS-1:0]  pixel_q, pixel_d;
  logic [ADDR_BITS-1:0]   x_q, x_d, y_q, y_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic [2*SERIAL_BITS-1:0] start_w, end_w;

  // two-flop synchronisers for all four bus wires, idle values on reset
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sel_s1_q <= 1'b1;
      sel_s2_q <= 1'b1;
      cmd_s1_q <= 1'b0;
      cmd_s2_q <= 1'b0;
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      dat_s1_q <= 1'b0;
      dat_s2_q <= 1'b0;
    end else begin
      sel_s1_q <= in_ser_sel;
      sel_s2_q <= sel_s1_q;
      cmd_s1_q <= in_ser_cmd;
      cmd_s2_q <= cmd_s1_q;
      clk_s1_q <= in_ser_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= in_ser_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign ser_rise = clk_s2_q & ~clk_s3_q;
  assign byte_val = {sh_q[SERIAL_BITS-2:0], dat_s2_q};

  // shift register and bit counter; deselect throws away a partial byte
  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    byte_done = 1'b0;
    if (sel_s2_q) begin
      cnt_d = '0;
    end else if (ser_rise) begin
      sh_d = byte_val;
      if (cnt_q == LAST_BIT) begin
        cnt_d     = '0;
        byte_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign start_w = {p_shi_q, p_slo_q};
  assign end_w   = {p_ehi_q, byte_val};

  // command decode, window parameter collection and pixel assembly
  always_comb begin
    state_d       = state_q;
    pidx_d        = pidx_q;
    p_shi_d       = p_shi_q;
    p_slo_d       = p_slo_q;
    p_ehi_d       = p_ehi_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    phase_d       = phase_q;
    pix_hi_d      = pix_hi_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    pixel_d       = pixel_q;
    x_d           = x_q;
    y_d           = y_q;
    pixel_valid_d = 1'b0;
    if (byte_done && !cmd_s2_q) begin
      cmd_valid_d = 1'b1;
      cmd_d       = byte_val;
      phase_d     = 1'b0;
      pidx_d      = 2'd0;
      state_d     = IDLE;
      case (byte_val)
        8'h2A: state_d = CASET;
        8'h2B: state_d = RASET;
        8'h2C: begin
          state_d = RAMWR;
          cx_d    = xs_q;
          cy_d    = ys_q;
        end
        8'h01: begin
          xs_d = '0;
          xe_d = XEND_RST;
          ys_d = '0;
          ye_d = YEND_RST;
        end
        default: state_d = IDLE;
      endcase
    end else if (byte_done) begin
      case (state_q)
        CASET, RASET: begin
          pidx_d = pidx_q + 2'd1;
          case (pidx_q)
            2'd0: p_shi_d = byte_val;
            2'd1: p_slo_d = byte_val;
            2'd2: p_ehi_d = byte_val;
            default: begin
              state_d = IDLE;
              if (state_q == CASET) begin
                xs_d = start_w[ADDR_BITS-1:0];
                xe_d = end_w[ADDR_BITS-1:0];
              end else begin
                ys_d = start_w[ADDR_BITS-1:0];
                ye_d = end_w[ADDR_BITS-1:0];
              end
            end
          endcase
        end
        RAMWR: begin
          if (!phase_q) begin
            pix_hi_d = byte_val;
            phase_d  = 1'b1;
          end else begin
            phase_d       = 1'b0;
            pixel_d       = {pix_hi_q, byte_val};
            x_d           = cx_q;
            y_d           = cy_q;
            pixel_valid_d = 1'b1;
            // an inverted window (start > end) wraps after every pixel
            if (cx_q == xe_q || xs_q > xe_q) begin
              cx_d = xs_q;
              if (cy_q == ye_q || ys_q > ye_q) cy_d = ys_q;
              else                             cy_d = cy_q + ONE;
            end else begin
              cx_d = cx_q + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state, window and output registers
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sh_q          <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      pidx_q        <= 2'd0;
      p_shi_q       <= '0;
      p_slo_q       <= '0;
      p_ehi_q       <= '0;
      xs_q          <= '0;
      xe_q          <= XEND_RST;
      ys_q          <= '0;
      ye_q          <= YEND_RST;
      cx_q          <= '0;
      cy_q          <= '0;
      phase_q       <= 1'b0;
      pix_hi_q      <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      pixel_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      pidx_q        <= pidx_d;
      p_shi_q       <= p_shi_d;
      p_slo_q       <= p_slo_d;
      p_ehi_q       <= p_ehi_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      phase_q       <= phase_d;
      pix_hi_q      <= pix_hi_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      pixel_q       <= pixel_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign out_cmd         = cmd_q;
  assign out_cmd_valid   = cmd_valid_q;
  assign out_pixel       = pixel_q;
  assign out_x           = x_q;
  assign out_y           = y_q;
  assign out_pixel_valid = pixel_valid_q;
  assign out_busy        = (state_q == RAMWR);

`ifdef LCD_SERIAL_RX_ERRCNT_EN
  logic [7:0] err_q;
  logic       err_inc;

  assign err_inc = (sel_s2_q && cnt_q != '0) ||
                   (byte_done && !cmd_s2_q && state_q == RAMWR && phase_q);

  // saturating error counter
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst)                     err_q <= 8'd0;
    else if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign out_err_count = err_q;
`endif

endmodule

// File: tb/tb_lcd_serial_rx.sv
// Bench for lcd_serial_rx: directed scenarios followed by random traffic,
// checked against a byte-level model of the command/window/pixel rules.
module tb_lcd_serial_rx;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       in_ser_sel = 1'b1;
  logic       in_ser_cmd = 1'b0;
  logic       in_ser_clk = 1'b0;
  logic       in_ser_data = 1'b0;
  logic [7:0] out_cmd;
  logic       out_cmd_valid;
  logic [15:0] out_pixel;
  logic [8:0] out_x, out_y;
  logic       out_pixel_valid;
  logic       out_busy;
`ifdef LCD_SERIAL_RX_ERRCNT_EN
  logic [7:0] out_err_count;
`endif

  lcd_serial_rx dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_ser_sel(in_ser_sel),
    .in_ser_cmd(in_ser_cmd), .in_ser_clk(in_ser_clk), .in_ser_data(in_ser_data),
    .out_cmd(out_cmd), .out_cmd_valid(out_cmd_valid), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_pixel_valid(out_pixel_valid),
`ifdef LCD_SERIAL_RX_ERRCNT_EN
    .out_err_count(out_err_count),
`endif
    .out_busy(out_busy)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  logic [33:0] got_pix[$], exp_pix[$];
  logic [7:0]  got_cmd[$], exp_cmd[$];

  // reference model state, kept at the level of whole bytes
  int         m_mode;  // 0 idle, 1 column params, 2 row params, 3 pixel write
  logic [7:0] m_prm[$];
  logic [7:0] m_half[$];
  int         m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_err;

  always @(negedge in_clk) begin
    if (in_rst) begin
      if (out_pixel_valid) got_pix.push_back({out_pixel, out_x, out_y});
      if (out_cmd_valid) got_cmd.push_back(out_cmd);
      if (out_pixel_valid && out_cmd_valid) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_prm.delete(); m_half.delete();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_cx = 0; m_cy = 0; m_err = 0;
    exp_pix.delete(); exp_cmd.delete(); got_pix.delete(); got_cmd.delete();
  endtask

  task automatic m_byte(input bit is_cmd, input logic [7:0] v);
    logic [15:0] s, e;
    if (is_cmd) begin
      exp_cmd.push_back(v);
      if (m_mode == 3 && m_half.size() == 1 && m_err < 255) m_err++;
      m_half.delete(); m_prm.delete();
      m_mode = 0;
      if (v == 8'h2A) m_mode = 1;
      else if (v == 8'h2B) m_mode = 2;
      else if (v == 8'h2C) begin m_mode = 3; m_cx = m_xs; m_cy = m_ys; end
      else if (v == 8'h01) begin m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; end
    end else if (m_mode == 1 || m_mode == 2) begin
      m_prm.push_back(v);
      if (m_prm.size() == 4) begin
        s = {m_prm[0], m_prm[1]};
        e = {m_prm[2], m_prm[3]};
        if (m_mode == 1) begin m_xs = s % 512; m_xe = e % 512; end
        else             begin m_ys = s % 512; m_ye = e % 512; end
        m_prm.delete(); m_mode = 0;
      end
    end else if (m_mode == 3) begin
      m_half.push_back(v);
      if (m_half.size() == 2) begin
        exp_pix.push_back({m_half[0], m_half[1], 9'(m_cx), 9'(m_cy)});
        m_half.delete();
        if (m_cx == m_xe || m_xs > m_xe) begin
          m_cx = m_xs;
          if (m_cy == m_ye || m_ys > m_ye) m_cy = m_ys;
          else m_cy = (m_cy + 1) % 512;
        end else m_cx = (m_cx + 1) % 512;
      end
    end
  endtask

  task automatic ser_bit(input logic b);
    @(negedge in_clk);
    in_ser_data = b; in_ser_clk = 1'b0;
    repeat (4) @(negedge in_clk);
    in_ser_clk = 1'b1;
    repeat (4) @(negedge in_clk);
    in_ser_clk = 1'b0;
  endtask

  task automatic send(input bit is_cmd, input logic [7:0] v);
    @(negedge in_clk);
    in_ser_sel = 1'b0;
    in_ser_cmd = ~is_cmd;
    for (int i = 7; i >= 0; i--) ser_bit(v[i]);
    m_byte(is_cmd, v);
  endtask

  task automatic send_partial(input int nbits);
    logic [7:0] r;
    r = 8'($urandom);
    @(negedge in_clk);
    in_ser_sel = 1'b0;
    in_ser_cmd = 1'b1;
    for (int i = 0; i < nbits; i++) ser_bit(r[i]);
    @(negedge in_clk);
    in_ser_sel = 1'b1;
    repeat (6) @(negedge in_clk);
    if (nbits > 0 && m_err < 255) m_err++;
  endtask

  task automatic send_window(input logic [7:0] c, input int st, input int en);
    logic [15:0] s16, e16;
    s16 = {7'($urandom), 9'(st)};
    e16 = {7'($urandom), 9'(en)};
    send(1, c);
    send(0, s16[15:8]); send(0, s16[7:0]);
    send(0, e16[15:8]); send(0, e16[7:0]);
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (8) @(negedge in_clk);
    chk({tag, ".npix"}, 40'(got_pix.size()), 40'(exp_pix.size()));
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) chk({tag, ".pix"}, 40'(got_pix[i]), 40'(exp_pix[i]));
    chk({tag, ".ncmd"}, 40'(got_cmd.size()), 40'(exp_cmd.size()));
    n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) chk({tag, ".cmd"}, 40'(got_cmd[i]), 40'(exp_cmd[i]));
    chk({tag, ".busy"}, 40'(out_busy), 40'(m_mode == 3));
`ifdef LCD_SERIAL_RX_ERRCNT_EN
    chk({tag, ".err"}, 40'(out_err_count), 40'(m_err));
`endif
    got_pix.delete(); exp_pix.delete(); got_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cmd"}, 40'(out_cmd), 40'(0));
    chk({tag, ".valids"}, 40'({out_cmd_valid, out_pixel_valid}), 40'(0));
    chk({tag, ".pixel"}, 40'({out_pixel, out_x, out_y}), 40'(0));
    chk({tag, ".busy"}, 40'(out_busy), 40'(0));
`ifdef LCD_SERIAL_RX_ERRCNT_EN
    chk({tag, ".err"}, 40'(out_err_count), 40'(0));
`endif
  endtask

  initial begin
    int op, a, b;
    m_reset();
    repeat (5) @(negedge in_clk);
    chk_zero("reset");
    in_rst = 1'b1;
    repeat (5) @(negedge in_clk);

    // basic RAMWR with the default window
    send(1, 8'h2C);
    send(0, 8'hF8); send(0, 8'h00); send(0, 8'h07); send(0, 8'hE0);
    check_events("ramwr_default");

    // small window with row wrap back to the start
    send_window(8'h2A, 40, 41);
    send_window(8'h2B, 52, 53);
    send(1, 8'h2C);
    for (int i = 0; i < 10; i++) send(0, 8'($urandom));
    check_events("window_2x2");

    // aborted byte followed by a complete command
    send_partial(5);
    send(1, 8'h2C);
    check_events("abort_then_cmd");

    // half pixel dropped by a command
    send(0, 8'hAB);
    send(1, 8'h00);
    check_events("half_pixel_drop");

    // incomplete CASET must not touch the window
    send(1, 8'h01);
    send(1, 8'h2A); send(0, 8'h00); send(0, 8'h10);
    send(1, 8'h2C); send(0, 8'h12); send(0, 8'h34);
    check_events("partial_caset");

    // random traffic, including inverted windows and truncated coordinates
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 7));
      case (op)
        0, 1: begin
          a = int'($urandom_range(0, 511));
          b = ($urandom_range(0, 3) == 0) ? (a + 511) % 512 : (a + int'($urandom_range(0, 3))) % 512;
          send_window((op == 0) ? 8'h2A : 8'h2B, a, b);
        end
        2, 3: begin
          send(1, 8'h2C);
          for (int k = int'($urandom_range(1, 9)); k > 0; k--) send(0, 8'($urandom));
        end
        4: for (int k = int'($urandom_range(1, 5)); k > 0; k--) send(0, 8'($urandom));
        5: send(1, 8'($urandom));
        6: send_partial(int'($urandom_range(1, 7)));
        default: send(1, 8'h01);
      endcase
      check_events("random");
    end

    // reset in the middle of a pixel write
    send(1, 8'h2C);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    repeat (6) @(negedge in_clk);
    in_rst = 1'b0;
    in_ser_sel = 1'b1; in_ser_clk = 1'b0;
    repeat (3) @(negedge in_clk);
    chk_zero("mid_reset");
    m_reset();
    in_rst = 1'b1;
    repeat (4) @(negedge in_clk);
    send(0, 8'h44); send(0, 8'h55);
    check_events("after_reset_no_ramwr");
    send(1, 8'h2C); send(0, 8'h66); send(0, 8'h77);
    check_events("after_reset_window");

    chk("no_overlap", 40'(overlap), 40'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
